// File: rtl/cond_branch_unit.sv
// Condition-code register and conditional-branch resolver for the execute stage.
// Optional branch statistics counters are enabled with `define BRANCH_STATS_EN.
module cond_branch_unit #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_Valid,
   input  logic             i_CC_WE,
   input  logic [3:0]       i_CCodes,
   input  logic             i_Is_Branch,
   input  logic [3:0]       i_Cond,
   input  logic [WIDTH-1:0] i_Target,
   output logic [3:0]       ro_CC_Reg,
   output logic             ro_Branch_Taken,
   output logic [WIDTH-1:0] ro_PC_Target,
   output logic             ro_Flush,
   output logic [31:0]      ro_Br_Count,
   output logic [31:0]      ro_Taken_Count
);

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned STAT_W = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         cc_d;
   logic               taken_d;
   logic [WIDTH-1:0]   target_d;
   logic               flush_d;
   logic               cond_true_c;

   // Condition decode; cc bit order is {V, C, N, Z}.
   function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] cc);
      logic z, n, c, v;
      logic r;
      z = cc[0];
      n = cc[1];
      c = cc[2];
      v = cc[3];
      case (cond)
         4'b0000: r = 1'b1;
         4'b1000: r = 1'b0;
         4'b0001: r = ~c;
         4'b1001: r = c;
         4'b0010: r = ~v;
         4'b1010: r = v;
         4'b0011: r = z;
         4'b1011: r = ~z;
         4'b0100: r = ~(n ^ v);
         4'b1100: r = n ^ v;
         4'b0101: r = ~(z | (n ^ v));
         4'b1101: r = z | (n ^ v);
         4'b0110: r = ~n;
         4'b1110: r = n;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Branches always resolve against the architectural register, never the incoming codes.
   assign cond_true_c = eval_cond(i_Cond, ro_CC_Reg);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cc_d     = ro_CC_Reg;
      taken_d  = 1'b0;
      target_d = ro_PC_Target;
      flush_d  = ro_Flush;
      case (state_q)
         IDLE: begin
            if (i_Valid) begin
               if (i_CC_WE) begin
                  cc_d = i_CCodes;
               end
               if (i_Is_Branch && cond_true_c) begin
                  taken_d  = 1'b1;
                  target_d = i_Target;
                  flush_d  = 1'b1;
                  cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
                  state_d  = FLUSH;
               end
            end
         end
         FLUSH: begin
            // Younger instructions are squashed: no CC writes or branch evaluation here.
            if (cnt_q == '0) begin
               flush_d = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            flush_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         ro_CC_Reg       <= '0;
         ro_Branch_Taken <= 1'b0;
         ro_PC_Target    <= '0;
         ro_Flush        <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         ro_CC_Reg       <= cc_d;
         ro_Branch_Taken <= taken_d;
         ro_PC_Target    <= target_d;
         ro_Flush        <= flush_d;
      end
   end

`ifdef BRANCH_STATS_EN
   logic              br_eval_c;
   logic              br_taken_c;
   logic [STAT_W-1:0] br_cnt_q;
   logic [STAT_W-1:0] tk_cnt_q;

   assign br_eval_c  = (state_q == IDLE) && i_Valid && i_Is_Branch;
   assign br_taken_c = br_eval_c && cond_true_c;

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         br_cnt_q <= '0;
         tk_cnt_q <= '0;
      end else begin
         if (br_eval_c && (br_cnt_q != '1)) begin
            br_cnt_q <= br_cnt_q + STAT_W'(1);
         end
         if (br_taken_c && (tk_cnt_q != '1)) begin
            tk_cnt_q <= tk_cnt_q + STAT_W'(1);
         end
      end
   end

   assign ro_Br_Count    = br_cnt_q;
   assign ro_Taken_Count = tk_cnt_q;
`else
   assign ro_Br_Count    = STAT_W'(0);
   assign ro_Taken_Count = STAT_W'(0);
`endif

endmodule

// File: tb/tb_cond_branch_unit.sv
// Scoreboard bench for cond_branch_unit: directed vectors push expected outputs,
// a monitor pops and compares them one cycle after each vector is applied.
module tb_cond_branch_unit;

   localparam int unsigned WIDTH = 32;
`ifdef BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic             i_Valid;
   logic             i_CC_WE;
   logic [3:0]       i_CCodes;
   logic             i_Is_Branch;
   logic [3:0]       i_Cond;
   logic [WIDTH-1:0] i_Target;
   logic [3:0]       ro_CC_Reg;
   logic             ro_Branch_Taken;
   logic [WIDTH-1:0] ro_PC_Target;
   logic             ro_Flush;
   logic [31:0]      ro_Br_Count;
   logic [31:0]      ro_Taken_Count;

   cond_branch_unit #(.WIDTH(WIDTH), .FLUSH_CYCLES(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .i_Valid         (i_Valid),
      .i_CC_WE         (i_CC_WE),
      .i_CCodes        (i_CCodes),
      .i_Is_Branch     (i_Is_Branch),
      .i_Cond          (i_Cond),
      .i_Target        (i_Target),
      .ro_CC_Reg       (ro_CC_Reg),
      .ro_Branch_Taken (ro_Branch_Taken),
      .ro_PC_Target    (ro_PC_Target),
      .ro_Flush        (ro_Flush),
      .ro_Br_Count     (ro_Br_Count),
      .ro_Taken_Count  (ro_Taken_Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, v, we, br;
      logic [3:0]  cc, cond;
      logic [31:0] tgt;
      logic [3:0]  ecc;
      logic        etk, efl;
      logic [31:0] etgt, ebr, etc;
   } vec_t;

   typedef struct {
      int          idx;
      logic [3:0]  ecc;
      logic        etk, efl;
      logic [31:0] etgt, ebr, etc;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   exp_t e;
   int   pass_cnt = 0;
   int   tot_cnt  = 0;

   function automatic vec_t mk(input logic rst, v, we, input logic [3:0] cc,
                               input logic br, input logic [3:0] cond, input logic [31:0] tgt,
                               input logic [3:0] ecc, input logic etk, input logic [31:0] etgt,
                               input logic efl, input logic [31:0] ebr, etc);
      vec_t x;
      x.rst = rst; x.v = v; x.we = we; x.cc = cc; x.br = br; x.cond = cond; x.tgt = tgt;
      x.ecc = ecc; x.etk = etk; x.etgt = etgt; x.efl = efl;
      x.ebr = STATS ? ebr : 32'd0;
      x.etc = STATS ? etc : 32'd0;
      return x;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act !== exp) begin
         $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   // Monitor: compare one expected snapshot per applied vector.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("cc_reg",  e.idx, 32'(ro_CC_Reg),       32'(e.ecc));
         chk("taken",   e.idx, 32'(ro_Branch_Taken), 32'(e.etk));
         chk("target",  e.idx, ro_PC_Target,         e.etgt);
         chk("flush",   e.idx, 32'(ro_Flush),        32'(e.efl));
         chk("br_cnt",  e.idx, ro_Br_Count,          e.ebr);
         chk("tk_cnt",  e.idx, ro_Taken_Count,       e.etc);
      end
   end

   initial begin
      exp_t x;
      reset = 1'b1; i_Valid = 1'b0; i_CC_WE = 1'b0; i_CCodes = 4'h0;
      i_Is_Branch = 1'b0; i_Cond = 4'h0; i_Target = '0;

      //        rst v  we cc       br cond     tgt     | ecc     tk tgt      fl br tc
      vecs.push_back(mk(1, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'h0,    0, 32'h0,   0, 0, 0)); // 0 reset
      vecs.push_back(mk(1, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'h0,    0, 32'h0,   0, 0, 0)); // 1 reset
      vecs.push_back(mk(0, 1, 1, 4'b0101, 0, 4'h0,    32'h0,   4'b0101, 0, 32'h0,   0, 0, 0)); // 2 CC write
      vecs.push_back(mk(0, 1, 0, 4'h0,    1, 4'b0011, 32'h40,  4'b0101, 1, 32'h40,  1, 1, 1)); // 3 BEQ taken
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'b0101, 0, 32'h40,  1, 1, 1)); // 4 flush 2
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'b0101, 0, 32'h40,  0, 1, 1)); // 5 flush done
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'b0101, 0, 32'h40,  0, 1, 1)); // 6 hold
      vecs.push_back(mk(0, 1, 1, 4'b1010, 0, 4'h0,    32'h0,   4'b1010, 0, 32'h40,  0, 1, 1)); // 7 N=1 V=1
      vecs.push_back(mk(0, 1, 0, 4'h0,    1, 4'b1100, 32'h77,  4'b1010, 0, 32'h40,  0, 2, 1)); // 8 BLT not taken
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'b1010, 0, 32'h40,  0, 2, 1)); // 9 idle
      vecs.push_back(mk(0, 1, 1, 4'h0,    1, 4'b1010, 32'h100, 4'h0,    1, 32'h100, 1, 3, 2)); // 10 WE+BVS uses old V
      vecs.push_back(mk(0, 1, 1, 4'hF,    1, 4'h0,    32'h200, 4'h0,    0, 32'h100, 1, 3, 2)); // 11 squashed
      vecs.push_back(mk(0, 1, 1, 4'hF,    1, 4'h0,    32'h200, 4'h0,    0, 32'h100, 0, 3, 2)); // 12 squashed, flush ends
      vecs.push_back(mk(0, 1, 1, 4'hF,    1, 4'h0,    32'h200, 4'hF,    1, 32'h200, 1, 4, 3)); // 13 same BRA now taken
      vecs.push_back(mk(1, 1, 1, 4'hF,    1, 4'h0,    32'h300, 4'h0,    0, 32'h0,   0, 0, 0)); // 14 reset mid-flush
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'h0,    0, 32'h0,   0, 0, 0)); // 15 idle after reset
      vecs.push_back(mk(0, 1, 0, 4'h0,    1, 4'h0,    32'h44,  4'h0,    1, 32'h44,  1, 1, 1)); // 16 BRA taken
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'h0,    0, 32'h44,  1, 1, 1)); // 17
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'h0,    0, 32'h44,  0, 1, 1)); // 18
      vecs.push_back(mk(0, 1, 0, 4'h0,    1, 4'b1000, 32'h99,  4'h0,    0, 32'h44,  0, 2, 1)); // 19 BNV
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'h0,    0, 32'h44,  0, 2, 1)); // 20
      vecs.push_back(mk(0, 1, 0, 4'h0,    1, 4'h0,    32'h80,  4'h0,    1, 32'h80,  1, 3, 2)); // 21 BRA taken
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'h0,    0, 32'h80,  1, 3, 2)); // 22
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'h0,    0, 32'h80,  0, 3, 2)); // 23
      vecs.push_back(mk(0, 1, 0, 4'h0,    1, 4'b0111, 32'h11,  4'h0,    0, 32'h80,  0, 4, 2)); // 24 reserved
      vecs.push_back(mk(0, 1, 0, 4'h0,    1, 4'b1111, 32'h12,  4'h0,    0, 32'h80,  0, 5, 2)); // 25 reserved
      vecs.push_back(mk(0, 1, 0, 4'h0,    1, 4'b0101, 32'h123, 4'h0,    1, 32'h123, 1, 6, 3)); // 26 BGT taken
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'h0,    0, 32'h123, 1, 6, 3)); // 27
      vecs.push_back(mk(0, 0, 0, 4'h0,    0, 4'h0,    32'h0,   4'h0,    0, 32'h123, 0, 6, 3)); // 28
      vecs.push_back(mk(0, 0, 1, 4'hF,    1, 4'h0,    32'h55,  4'h0,    0, 32'h123, 0, 6, 3)); // 29 invalid ignored
      vecs.push_back(mk(0, 1, 0, 4'h0,    1, 4'b0001, 32'h66,  4'h0,    1, 32'h66,  1, 7, 4)); // 30 BCC, C=0

      foreach (vecs[i]) begin
         @(negedge clk);
         reset = vecs[i].rst; i_Valid = vecs[i].v; i_CC_WE = vecs[i].we; i_CCodes = vecs[i].cc;
         i_Is_Branch = vecs[i].br; i_Cond = vecs[i].cond; i_Target = vecs[i].tgt;
         x.idx = i; x.ecc = vecs[i].ecc; x.etk = vecs[i].etk; x.etgt = vecs[i].etgt;
         x.efl = vecs[i].efl; x.ebr = vecs[i].ebr; x.etc = vecs[i].etc;
         exp_q.push_back(x);
      end
      @(negedge clk);
      i_Valid = 1'b0; i_CC_WE = 1'b0; i_Is_Branch = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      tot_cnt++;
      if (exp_q.size() != 0) begin
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end else begin
         pass_cnt++;
      end
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
